// File: rtl/adder_rr_pipe_if.sv
// Tagged FIFO bank handshakes used between arithmetic actors.
// The actor side writes results and pops operand heads.
interface write_interface #(
  parameter int WIDTH = 28
) ();
  logic [WIDTH-1:0] din;
  logic             write;
  logic             full;

  modport actor (
    output din,
    output write,
    input  full
  );

  modport fifo (
    input  din,
    input  write,
    output full
  );
endinterface

interface read_interface #(
  parameter int WIDTH = 28,
  parameter int FLUX  = 2
) ();
  logic [WIDTH-1:0] dout;
  logic [FLUX-1:0]  empty;
  logic [FLUX-1:0]  read;

  modport actor (
    input  dout,
    input  empty,
    output read
  );

  modport fifo (
    output dout,
    output empty,
    input  read
  );
endinterface

// File: rtl/adder_rr_pipe.sv
// Multi-flux add/sub actor: round-robin flux grant, one registered
// output slot, optional saturation and sticky per-flux overflow.
module adder_rr_pipe #(
  parameter int              FLUX       = 2,
  parameter int              DATA_WIDTH = 27,
  parameter logic [FLUX-1:0] SUB_MASK   = '0,
  parameter bit              SATURATE   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  write_interface.actor   write_port,
  read_interface.actor    read_port_A,
  read_interface.actor    read_port_B,
  output logic [FLUX-1:0] ovf
);
  localparam int TAG_WIDTH = $clog2(FLUX);
  localparam int WIDTH     = DATA_WIDTH + TAG_WIDTH;
  localparam int DW        = DATA_WIDTH;

  logic [FLUX-1:0]      elig;
  logic                 can_acc;
  logic                 found;
  logic                 grant;
  logic [TAG_WIDTH-1:0] g;
  logic [TAG_WIDTH-1:0] last_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [WIDTH-1:0]     out_data_d;
  logic [FLUX-1:0]      ovf_q;
  logic [FLUX-1:0]      rd_d;
  logic signed [DW:0]   a_x;
  logic signed [DW:0]   b_x;
  logic signed [DW:0]   sum;
  logic                 ovf_hit;
  logic [DW-1:0]        res;

  assign elig    = ~read_port_A.empty & ~read_port_B.empty;
  assign can_acc = ~out_valid_q | ~write_port.full;

  // Search starts just after the last served flux.
  always_comb begin
    found = 1'b0;
    g     = '0;
    for (int k = 1; k <= FLUX; k++) begin
      if (!found &&
          elig[TAG_WIDTH'((int'(last_q) + k) % FLUX)]) begin
        found = 1'b1;
        g     = TAG_WIDTH'((int'(last_q) + k) % FLUX);
      end
    end
  end

  assign grant = found & can_acc & ~rst;

  always_comb begin
    rd_d = '0;
    if (grant) rd_d[g] = 1'b1;
  end

  assign read_port_A.read = rd_d;
  assign read_port_B.read = rd_d;

  always_comb begin
    a_x = {read_port_A.dout[DW-1], read_port_A.dout[DW-1:0]};
    b_x = {read_port_B.dout[DW-1], read_port_B.dout[DW-1:0]};
    sum = SUB_MASK[g] ? a_x - b_x : a_x + b_x;
    ovf_hit = sum[DW] ^ sum[DW-1];
    res = sum[DW-1:0];
    if (SATURATE && ovf_hit) begin
      res = sum[DW] ? {1'b1, {(DW-1){1'b0}}}
                    : {1'b0, {(DW-1){1'b1}}};
    end
    out_data_d = {g, res};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      last_q      <= TAG_WIDTH'(FLUX - 1);
      ovf_q       <= '0;
    end else begin
      if (grant) begin
        out_valid_q <= 1'b1;
        out_data_q  <= out_data_d;
        last_q      <= g;
        if (ovf_hit) ovf_q[g] <= 1'b1;
      end else if (write_port.write) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // A result held across reset is dropped, never written.
  assign write_port.write = out_valid_q & ~write_port.full & ~rst;
  assign write_port.din   = (out_valid_q & ~rst) ? out_data_q : '0;
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_adder_rr_pipe.sv
// Directed bench for adder_rr_pipe: two instances (wrap with a
// subtracting flux 1, and saturating add) fed by small FIFO models.
module tb_adder_rr_pipe;
  localparam int W = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic full0 = 1'b0;
  logic full1 = 1'b0;
  logic [1:0] ovf0;
  logic [1:0] ovf1;
  int ntests = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  write_interface #(.WIDTH(W)) wp0 ();
  write_interface #(.WIDTH(W)) wp1 ();
  read_interface #(.WIDTH(W), .FLUX(2)) ra0 ();
  read_interface #(.WIDTH(W), .FLUX(2)) rb0 ();
  read_interface #(.WIDTH(W), .FLUX(2)) ra1 ();
  read_interface #(.WIDTH(W), .FLUX(2)) rb1 ();

  adder_rr_pipe #(
    .FLUX(2), .DATA_WIDTH(27),
    .SUB_MASK(2'b10), .SATURATE(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .write_port(wp0),
    .read_port_A(ra0), .read_port_B(rb0),
    .ovf(ovf0)
  );

  adder_rr_pipe #(
    .FLUX(2), .DATA_WIDTH(27),
    .SUB_MASK(2'b00), .SATURATE(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .write_port(wp1),
    .read_port_A(ra1), .read_port_B(rb1),
    .ovf(ovf1)
  );

  // FIFO model indexed [dut][port A/B][flux][slot]
  logic [W-1:0] mem [2][2][2][16];
  int hd [2][2][2];
  int tl [2][2][2];
  logic [1:0]   emp [2][2];
  logic [W-1:0] hdv [2][2];
  logic [1:0]   rd  [2][2];
  logic [W-1:0] oq0 [$];

  assign rd[0][0] = ra0.read;
  assign rd[0][1] = rb0.read;
  assign rd[1][0] = ra1.read;
  assign rd[1][1] = rb1.read;

  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        for (int f = 0; f < 2; f++)
          emp[d][p][f] = (hd[d][p][f] == tl[d][p][f]);
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        hdv[d][p] = '0;
        for (int f = 0; f < 2; f++)
          if (rd[d][p][f])
            hdv[d][p] = mem[d][p][f][hd[d][p][f] % 16];
      end
  end

  assign ra0.empty = emp[0][0];
  assign rb0.empty = emp[0][1];
  assign ra1.empty = emp[1][0];
  assign rb1.empty = emp[1][1];
  assign ra0.dout  = hdv[0][0];
  assign rb0.dout  = hdv[0][1];
  assign ra1.dout  = hdv[1][0];
  assign rb1.dout  = hdv[1][1];
  assign wp0.full  = full0;
  assign wp1.full  = full1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        for (int f = 0; f < 2; f++)
          if (rd[d][p][f]) hd[d][p][f] <= hd[d][p][f] + 1;
    if (wp0.write) oq0.push_back(wp0.din);
  end

  // Tag bits of pushed words are set to 1 so ignoring them is exercised.
  task automatic push(input int d, input int p, input int f,
                      input int v);
    mem[d][p][f][tl[d][p][f] % 16] = {1'b1, v[26:0]};
    tl[d][p][f] = tl[d][p][f] + 1;
  endtask

  task automatic pushab(input int d, input int f,
                        input int a, input int b);
    push(d, 0, f, a);
    push(d, 1, f, b);
  endtask

  task automatic flush();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        for (int f = 0; f < 2; f++)
          tl[d][p][f] = hd[d][p][f];
  endtask

  function automatic logic [W-1:0] ex(input int t, input int v);
    logic [W-1:0] r;
    r = {t[0], v[26:0]};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int b0;
    int v;

    // reset: reads suppressed even with data present
    rst = 1'b1;
    pushab(0, 0, 1, 1);
    nxt();
    chk("rst_read", W'(ra0.read), W'(2'b00));
    chk("rst_write", W'(wp0.write), W'(1'b0));
    chk("rst_din", wp0.din, '0);
    chk("rst_ovf", W'(ovf0), W'(2'b00));
    flush();
    rst = 1'b0;

    // single flux-0 add, latency one
    nxt();
    pushab(0, 0, 100, -30);
    #1;
    chk("s_readA", W'(ra0.read), W'(2'b01));
    chk("s_readB", W'(rb0.read), W'(2'b01));
    nxt();
    chk("s_write", W'(wp0.write), W'(1'b1));
    chk("s_din", wp0.din, ex(0, 70));
    chk("s_read_off", W'(ra0.read), W'(2'b00));
    nxt();
    chk("s_write_off", W'(wp0.write), W'(1'b0));

    // round robin with both fluxes loaded
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    b0 = oq0.size();
    for (int k = 1; k <= 4; k++) begin
      pushab(0, 0, 10 * k, k);
      pushab(0, 1, 7 * k, 2 * k);
    end
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_read%0d", i), W'(ra0.read),
          (i % 2 == 0) ? W'(2'b01) : W'(2'b10));
      if (i > 0) chk($sformatf("rr_write%0d", i),
                     W'(wp0.write), W'(1'b1));
      nxt();
    end
    chk("rr_last_write", W'(wp0.write), W'(1'b1));
    chk("rr_idle_read", W'(ra0.read), W'(2'b00));
    nxt();
    chk("rr_drained", W'(wp0.write), W'(1'b0));
    chk("rr_count", W'(oq0.size() - b0), W'(8));
    for (int k = 0; k < 8; k++) begin
      v = (k % 2 == 0) ? 11 * (k / 2 + 1) : 5 * (k / 2 + 1);
      chk($sformatf("rr_out%0d", k), oq0[b0 + k], ex(k % 2, v));
    end

    // downstream full stall
    b0 = oq0.size();
    pushab(0, 0, 50, 1);
    pushab(0, 0, 60, 2);
    full0 = 1'b1;
    #1;
    chk("st_first_read", W'(ra0.read), W'(2'b01));
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk($sformatf("st_din%0d", i), wp0.din, ex(0, 51));
      chk($sformatf("st_write%0d", i), W'(wp0.write), W'(1'b0));
      chk($sformatf("st_read%0d", i), W'(ra0.read), W'(2'b00));
    end
    full0 = 1'b0;
    #1;
    chk("st_rel_write", W'(wp0.write), W'(1'b1));
    chk("st_rel_read", W'(ra0.read), W'(2'b01));
    nxt();
    chk("st_next_din", wp0.din, ex(0, 62));
    chk("st_next_write", W'(wp0.write), W'(1'b1));
    nxt();
    chk("st_count", W'(oq0.size() - b0), W'(2));
    chk("st_out0", oq0[b0], ex(0, 51));
    chk("st_out1", oq0[b0 + 1], ex(0, 62));

    // wrapping overflow and saturating overflow
    pushab(0, 0, 67108863, 1);
    pushab(1, 0, 67108863, 1);
    nxt();
    chk("wrap_din", wp0.din, ex(0, -67108864));
    chk("wrap_ovf", W'(ovf0), W'(2'b01));
    chk("sat_din", wp1.din, ex(0, 67108863));
    chk("sat_ovf", W'(ovf1), W'(2'b01));
    pushab(1, 1, -67108864, -1);
    nxt();
    chk("wrap_sticky", W'(ovf0), W'(2'b01));
    chk("satn_din", wp1.din, ex(1, -67108864));
    chk("satn_ovf", W'(ovf1), W'(2'b11));

    // per-flux subtract select
    pushab(0, 1, 5, 9);
    pushab(0, 0, 5, 9);
    nxt();
    chk("sub_din", wp0.din, ex(1, -4));
    nxt();
    chk("add_din", wp0.din, ex(0, 14));

    // reset while holding a stalled result
    full0 = 1'b1;
    b0 = oq0.size();
    pushab(0, 1, 5, 9);
    #1;
    chk("rh_read", W'(ra0.read), W'(2'b00));
    nxt();
    chk("rh_hold", wp0.din, ex(0, 14));
    rst = 1'b1;
    #1;
    chk("rh_write", W'(wp0.write), W'(1'b0));
    chk("rh_din", wp0.din, '0);
    chk("rh_rd", W'(ra0.read), W'(2'b00));
    nxt();
    chk("rh_ovf", W'(ovf0), W'(2'b00));
    rst = 1'b0;
    full0 = 1'b0;
    pushab(0, 0, 2, 3);
    #1;
    chk("rh_first", W'(ra0.read), W'(2'b01));
    nxt();
    chk("rh_out0", wp0.din, ex(0, 5));
    nxt();
    chk("rh_out1", wp0.din, ex(1, -4));
    nxt();
    chk("rh_idle", W'(wp0.write), W'(1'b0));
    chk("rh_count", W'(oq0.size() - b0), W'(2));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/adder_rr_pipe.md
# adder_rr_pipe

Parametrised, registered successor of the multi-flux 27-bit adder actor. Adds or subtracts (selected per flux) the heads of two tagged input FIFO banks and writes `{tag, result}` to one output FIFO through a one-entry registered output stage. Flux arbitration is round-robin instead of fixed priority. Optional saturation with per-flux sticky overflow flags. Sits between the tagged FIFO banks of the HEVC dataflow network, like the other arithmetic actors.

## Interface
- `FLUX`, 2: number of interleaved data fluxes; legal range 2..16.
- `DATA_WIDTH`, 27: signed operand/result width.
- `SUB_MASK`, 0: `FLUX`-bit vector; bit i=1 means flux i computes A−B, otherwise A+B.
- `SATURATE`, 0: 1 clamps to signed range on overflow; 0 wraps (two's complement).
- Derived: `TAG_WIDTH` = $clog2(FLUX); `WIDTH` = DATA_WIDTH+TAG_WIDTH.

- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `write_port` write_interface.actor: `din` [WIDTH-1:0] out, `write` out, `full` in.
- `read_port_A` read_interface.actor: `dout` [WIDTH-1:0] in, `empty` [FLUX-1:0] in, `read` [FLUX-1:0] out.
- `read_port_B` read_interface.actor: same as A.
- `ovf` out [FLUX-1:0]: sticky overflow flag per flux.

## Operation
- Flux i is eligible when `read_port_A.empty[i]==0` and `read_port_B.empty[i]==0`.
- Stage can accept when `out_valid==0` or `write_port.full==0` (draining this cycle).
- Grant: if the stage can accept, pick the first eligible flux searching from `last+1` modulo FLUX. The `last` register updates to the granted index on every grant.
- On grant g in the same cycle:
  - `read_port_A.read[g]=read_port_B.read[g]=1`; all other read bits are 0.
  - Operands are `dout[DATA_WIDTH-1:0]`; the tag bits of `dout` are ignored.
  - Result is computed at DATA_WIDTH+1 bits: `A+B` or `A−B` per `SUB_MASK[g]`.
- Overflow: bit DATA_WIDTH of the result differs from bit DATA_WIDTH−1.
  - SATURATE=1: clamp to +2^(DATA_WIDTH−1)−1 or −2^(DATA_WIDTH−1) according to the sign bit.
  - SATURATE=0: keep the low DATA_WIDTH bits.
  - Either mode: `ovf[g]` sets at the next edge and stays set until `rst`.
- Registered at the edge: `out_data={g[TAG_WIDTH-1:0], result}`, `out_valid=1`.
- Output: `write_port.write = out_valid & ~write_port.full`; `write_port.din = out_data` (`'0` when `out_valid==0`).
- After a write with no new grant, `out_valid` clears at the edge.
- Reads are combinational from the `empty`/`full` inputs and registered state. They never depend on `dout`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `last=FLUX-1` (flux 0 is served first), `ovf=0`. While `rst==1`: `read=0`, `write=0`, `din=0`.
- Reset mid-operation: the held result is discarded, never written. Reads are suppressed in the `rst` cycle.
- Latency: a read in cycle n produces `write=1` in cycle n+1 if `full==0`.
- Throughput: one result per cycle while the downstream is not full and some flux is eligible.
- Full output stall:
  - `out_valid=1` and `full=1`: no grant, no read, `din` holds stable.
  - `full` deasserts: the write and a new grant happen in the same cycle (no bubble).
- Fairness: with all fluxes continuously eligible, grants cycle 0,1,…,FLUX−1,0. No flux waits more than FLUX−1 grants.
- A flux whose A and B availability are out of step is never partially read. Both reads fire together or not at all.

## Test plan
- FLUX=2, DW=27, wrap. Flux 0 only: A=100, B=−30 → one cycle later `write=1`, `din={1'b0, 70}`, `read_port_*.read=2'b01` for exactly one cycle.
- Both fluxes with 4 entries each and `full=0` → grants 0,1,0,1,… on consecutive cycles. Output tags alternate, one write per cycle.
- `full` held high for 5 cycles after the first result → `din` stable, `write=0`, no reads. On release, the held result is written and the next read happens in the same cycle.
- SATURATE=1, A=67108863, B=1 → `din` result 67108863 and `ovf[0]=1`. SATURATE=0, same operands → result −67108864 and `ovf[0]=1`.
- SUB_MASK=2'b10, flux 1: A=5, B=9 → result −4, tag 1. Flux 0 with the same operands → 14.
- `rst` asserted while `out_valid=1` and `full=1` → after reset, `write=0`, `ovf=0`, and the first grant goes to flux 0.
